// File: rtl/req_latch_pkg.sv
// -----------------------------------------------------------------------------
// req_latch_pkg
// Shared constants and helpers for the request capture stage that feeds the
// 8:3 priority encoder.
//   N        : number of request lines (fixed at 8 to match the encoder)
//   IDX_W    : acknowledge index width, log2(N)
//   MASK_RST : enable mask value after reset (all lines enabled)
//   onehot() : index -> one-hot line vector
// -----------------------------------------------------------------------------
package req_latch_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    localparam logic [N-1:0] MASK_RST = 8'hFF;

    // One-hot line vector selecting line idx.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

endpackage

// File: rtl/req_sync.sv
// -----------------------------------------------------------------------------
// req_sync
// W-bit two-flop synchronizer, one independent chain per bit. Used in front of
// the edge detector when the request lines are asynchronous to clk.
// Ports:
//   clk  : destination clock
//   rst  : asynchronous, active-high reset (both stages clear to 0)
//   din  : asynchronous input bits
//   dout : synchronized bits, din delayed by two rising edges
// -----------------------------------------------------------------------------
module req_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/req_latch.sv
// -----------------------------------------------------------------------------
// req_latch
// Eight-line request capture stage. Rising edges on the request lines are held
// in a pending register until acknowledged by index; the enabled pending vector
// drives the priority encoder, whose code returns as ack_idx.
// Build option: define REQ_SYNC_EN to pass req through a two-flop synchronizer
// before edge detection (request latency 3 cycles instead of 1).
// Ports:
//   clk      : clock, all state on its rising edge
//   rst      : asynchronous, active-high reset
//   req      : raw request levels
//   mask_wr  : load mask from mask_din at this edge
//   mask_din : new enable mask (1 = line enabled)
//   mask     : current enable mask
//   ack      : acknowledge strobe
//   ack_idx  : index of the line being acknowledged
//   vec      : pend & mask, encoder input
//   irq      : |vec
//   ovf      : sticky per-line overflow flags (rise while still pending)
//   ack_err  : one-cycle pulse, previous ack targeted a non-pending line
// -----------------------------------------------------------------------------
module req_latch
    import req_latch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mask_wr,
    input  logic [N-1:0]     mask_din,
    output logic [N-1:0]     mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N-1:0]     vec,
    output logic             irq,
    output logic [N-1:0]     ovf,
    output logic             ack_err
);

    logic [N-1:0] req_s;
    logic [N-1:0] prev;
    logic [N-1:0] pend;
    logic [N-1:0] rise;
    logic [N-1:0] clr;

`ifdef REQ_SYNC_EN
    req_sync #(.W(N)) u_req_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (req),
        .dout (req_s)
    );
`else
    // req is already synchronous to clk in this build.
    assign req_s = req;
`endif

    // NOTE: every signal in always_comb is assigned on all paths so no latch
    // is inferred; both are full-width assignments here.
    always_comb begin
        rise = req_s & ~prev;
        clr  = ack ? onehot(ack_idx) : '0;
    end

    // NOTE: state uses non-blocking assignments so every right-hand side sees
    // the pre-edge value; ovf and ack_err deliberately read the old pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            pend    <= '0;
            ovf     <= '0;
            mask    <= MASK_RST;
            ack_err <= 1'b0;
        end else begin
            prev    <= req_s;
            // A rise on the same cycle as its ack wins: the new event stays.
            pend    <= (pend & ~clr) | rise;
            // Overflow only when a new event lands on a line not being cleared.
            ovf     <= (ovf & ~clr) | (rise & pend & ~clr);
            ack_err <= ack & ~pend[ack_idx];
            if (mask_wr) begin
                mask <= mask_din;
            end
        end
    end

    // Masking only gates the view; pend keeps capturing behind the mask.
    assign vec = pend & mask;
    assign irq = |vec;

endmodule

// File: tb/tb_req_latch.sv
// -----------------------------------------------------------------------------
// tb_req_latch
// Directed testbench for req_latch. Inputs change 1 ns after a rising edge and
// outputs are sampled there as well, well away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_req_latch;

`ifdef REQ_SYNC_EN
    localparam int REQ_LAT = 3;
`else
    localparam int REQ_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_din = 8'h00;
    logic [7:0] mask;
    logic       ack = 1'b0;
    logic [2:0] ack_idx = 3'd0;
    logic [7:0] vec;
    logic       irq;
    logic [7:0] ovf;
    logic       ack_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    req_latch dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .mask     (mask),
        .ack      (ack),
        .ack_idx  (ack_idx),
        .vec      (vec),
        .irq      (irq),
        .ovf      (ovf),
        .ack_err  (ack_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a new req level and advance so that the following step() is the
    // edge at which the edge detector sees it.
    task automatic set_req(input logic [7:0] v);
        req = v;
        repeat (REQ_LAT - 1) step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL reset_vec: got %h expected %h", vec, 8'h00); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected %b", irq, 1'b0); end
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL reset_ovf: got %h expected %h", ovf, 8'h00); end
        n_checks++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL reset_mask: got %h expected %h", mask, 8'hFF); end
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected %b", ack_err, 1'b0); end
        rst = 1'b0;
        step();
        // Build pend = A5, ovf[0] = 1, mask = F7.
        set_req(8'hA5); step();
        set_req(8'h00); step();
        set_req(8'h01); step();
        mask_wr = 1'b1; mask_din = 8'hF7; step(); mask_wr = 1'b0;
        n_checks++; if (vec !== 8'hA5) begin n_fail++; $display("FAIL pre_reset_vec: got %h expected %h", vec, 8'hA5); end
        n_checks++; if (ovf !== 8'h01) begin n_fail++; $display("FAIL pre_reset_ovf: got %h expected %h", ovf, 8'h01); end
        n_checks++; if (mask !== 8'hF7) begin n_fail++; $display("FAIL pre_reset_mask: got %h expected %h", mask, 8'hF7); end
        // Asynchronous reset in mid-cycle, req[0] still high.
        #2 rst = 1'b1;
        #1;
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL async_reset_vec: got %h expected %h", vec, 8'h00); end
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL async_reset_ovf: got %h expected %h", ovf, 8'h00); end
        n_checks++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL async_reset_mask: got %h expected %h", mask, 8'hFF); end
        step(); step();
        rst = 1'b0;
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL release_vec: got %h expected %h", vec, 8'h00); end
        repeat (REQ_LAT) step();
        n_checks++; if (vec !== 8'h01) begin n_fail++; $display("FAIL held_req_vec: got %h expected %h", vec, 8'h01); end
        ack = 1'b1; ack_idx = 3'd0; step(); ack = 1'b0;
        set_req(8'h00); step();
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL reset_cleanup_vec: got %h expected %h", vec, 8'h00); end
    endtask

    task automatic test_basic();
        set_req(8'h90); step();
        n_checks++; if (vec !== 8'h90) begin n_fail++; $display("FAIL basic_vec: got %h expected %h", vec, 8'h90); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %b expected %b", irq, 1'b1); end
        ack = 1'b1; ack_idx = 3'd7; step();
        n_checks++; if (vec !== 8'h10) begin n_fail++; $display("FAIL basic_ack7_vec: got %h expected %h", vec, 8'h10); end
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL basic_ack7_err: got %b expected %b", ack_err, 1'b0); end
        ack_idx = 3'd4; step(); ack = 1'b0;
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL basic_ack4_vec: got %h expected %h", vec, 8'h00); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_ack4_irq: got %b expected %b", irq, 1'b0); end
        set_req(8'h00); step();
    endtask

    task automatic test_simultaneous();
        set_req(8'h08); step();
        n_checks++; if (vec !== 8'h08) begin n_fail++; $display("FAIL sim_first_vec: got %h expected %h", vec, 8'h08); end
        set_req(8'h00); step();
        // New rise on line 3 together with its ack.
        set_req(8'h08); ack = 1'b1; ack_idx = 3'd3; step(); ack = 1'b0;
        n_checks++; if (vec !== 8'h08) begin n_fail++; $display("FAIL sim_rise_ack_vec: got %h expected %h", vec, 8'h08); end
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL sim_rise_ack_ovf: got %h expected %h", ovf, 8'h00); end
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL sim_rise_ack_err: got %b expected %b", ack_err, 1'b0); end
        set_req(8'h00); step();
        set_req(8'h08); step();
        n_checks++; if (ovf !== 8'h08) begin n_fail++; $display("FAIL sim_overflow: got %h expected %h", ovf, 8'h08); end
        ack = 1'b1; ack_idx = 3'd3; step(); ack = 1'b0;
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL sim_ovf_clear: got %h expected %h", ovf, 8'h00); end
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL sim_ack_vec: got %h expected %h", vec, 8'h00); end
        set_req(8'h00); step();
    endtask

    task automatic test_mask();
        mask_wr = 1'b1; mask_din = 8'h0F; step(); mask_wr = 1'b0;
        n_checks++; if (mask !== 8'h0F) begin n_fail++; $display("FAIL mask_load: got %h expected %h", mask, 8'h0F); end
        set_req(8'h40); step();
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL mask_hidden_vec: got %h expected %h", vec, 8'h00); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_hidden_irq: got %b expected %b", irq, 1'b0); end
        mask_wr = 1'b1; mask_din = 8'hFF; step(); mask_wr = 1'b0;
        n_checks++; if (vec !== 8'h40) begin n_fail++; $display("FAIL mask_reveal_vec: got %h expected %h", vec, 8'h40); end
        n_checks++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL mask_reveal_mask: got %h expected %h", mask, 8'hFF); end
        // Masked pending line can still be acknowledged legally.
        mask_wr = 1'b1; mask_din = 8'h0F; step(); mask_wr = 1'b0;
        ack = 1'b1; ack_idx = 3'd6; step(); ack = 1'b0;
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL mask_ack_err: got %b expected %b", ack_err, 1'b0); end
        mask_wr = 1'b1; mask_din = 8'hFF; step(); mask_wr = 1'b0;
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL mask_ack_vec: got %h expected %h", vec, 8'h00); end
        set_req(8'h00); step();
    endtask

    task automatic test_illegal_ack();
        ack = 1'b1; ack_idx = 3'd2; step(); ack = 1'b0;
        n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL illegal_ack_err: got %b expected %b", ack_err, 1'b1); end
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL illegal_ack_vec: got %h expected %h", vec, 8'h00); end
        step();
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL illegal_ack_pulse: got %b expected %b", ack_err, 1'b0); end
    endtask

    task automatic test_back_to_back();
        set_req(8'h03); step();
        ack = 1'b1; ack_idx = 3'd0; step();
        n_checks++; if (vec !== 8'h02) begin n_fail++; $display("FAIL b2b_first_vec: got %h expected %h", vec, 8'h02); end
        ack_idx = 3'd1; step();
        n_checks++; if (vec !== 8'h00) begin n_fail++; $display("FAIL b2b_second_vec: got %h expected %h", vec, 8'h00); end
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL b2b_second_err: got %b expected %b", ack_err, 1'b0); end
        step(); ack = 1'b0;
        n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL b2b_repeat_err: got %b expected %b", ack_err, 1'b1); end
        step();
        n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err_clear: got %b expected %b", ack_err, 1'b0); end
        set_req(8'h00); step();
    endtask

`ifdef REQ_SYNC_EN
    task automatic test_sync();
        req = 8'h01;
        step();
        n_checks++; if (vec[0] !== 1'b0) begin n_fail++; $display("FAIL sync_edge1: got %b expected %b", vec[0], 1'b0); end
        step();
        n_checks++; if (vec[0] !== 1'b0) begin n_fail++; $display("FAIL sync_edge2: got %b expected %b", vec[0], 1'b0); end
        step();
        n_checks++; if (vec[0] !== 1'b1) begin n_fail++; $display("FAIL sync_edge3: got %b expected %b", vec[0], 1'b1); end
        ack = 1'b1; ack_idx = 3'd0; step(); ack = 1'b0;
        set_req(8'h00); step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_mask();
        test_illegal_ack();
        test_back_to_back();
`ifdef REQ_SYNC_EN
        test_sync();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
